// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops with a valid/ready handshake.
// Define ALU_MULTICYCLE_MULT_EN to add the MUL state and shift-add MULTU (functn 011001).
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       functn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             negativeFlag,
  output logic             zeroFlag,
  output logic             carryFlag,
  output logic             overflowFlag,
  output logic             illegalFlag
);
  localparam int SH_W = $clog2(WIDTH);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [SH_W-1:0]         shamt;
  logic [WIDTH:0]          sum;
  logic [WIDTH-1:0]        diff;
  logic [WIDTH-1:0]        res;
  logic                    res_c;
  logic                    res_v;
  logic                    res_ill;
  logic                    accept;
  logic                    busy;
  logic                    is_mul;

  assign a_s      = A;
  assign b_s      = B;
  assign shamt    = B[SH_W-1:0];
  assign sum      = {1'b0, A} + {1'b0, B};
  assign diff     = A - B;
  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_ill = 1'b0;
    case (functn)
      6'b100000: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      6'b100001: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
      end
      6'b100010: begin
        res   = diff;
        res_c = (A < B);
        res_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      6'b100011: begin
        res   = diff;
        res_c = (A < B);
      end
      6'b100100: res = A & B;
      6'b100101: res = A | B;
      6'b100110: res = A ^ B;
      6'b100111: res = ~(A | B);
      6'b101010: res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      6'b101011: res = {{(WIDTH-1){1'b0}}, (A < B)};
      6'b000000: res = A << shamt;
      6'b000010: res = A >> shamt;
      6'b000011: res = a_s >>> shamt;
      default:   res_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULTICYCLE_MULT_EN
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     partial;

  assign busy      = (state == MUL);
  assign is_mul    = (functn == 6'b011001);
  // Upper half accumulates the multiplicand when the current multiplier LSB is set.
  assign partial   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {partial, prod[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mcand <= A;
      prod  <= {{WIDTH{1'b0}}, B};
    end else if (busy) begin
      prod  <= prod_next;
    end
  end
`else
  assign busy   = 1'b0;
  assign is_mul = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out          <= '0;
      hi           <= '0;
      negativeFlag <= 1'b0;
      zeroFlag     <= 1'b0;
      carryFlag    <= 1'b0;
      overflowFlag <= 1'b0;
      illegalFlag  <= 1'b0;
`ifdef ALU_MULTICYCLE_MULT_EN
      state        <= IDLE;
      count        <= '0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && !is_mul) begin
        out_valid    <= 1'b1;
        out          <= res;
        hi           <= '0;
        negativeFlag <= res[WIDTH-1];
        zeroFlag     <= (res == '0);
        carryFlag    <= res_c;
        overflowFlag <= res_v;
        illegalFlag  <= res_ill;
      end
`ifdef ALU_MULTICYCLE_MULT_EN
      if (accept && is_mul) begin
        state <= MUL;
        count <= '0;
      end else if (busy) begin
        // Final iteration writes the result directly so it appears WIDTH+1 cycles after acceptance.
        if (count == CNT_LAST) begin
          state        <= IDLE;
          count        <= '0;
          out_valid    <= 1'b1;
          out          <= prod_next[WIDTH-1:0];
          hi           <= prod_next[2*WIDTH-1:WIDTH];
          negativeFlag <= prod_next[2*WIDTH-1];
          zeroFlag     <= (prod_next == '0);
          carryFlag    <= 1'b0;
          overflowFlag <= 1'b0;
          illegalFlag  <= 1'b0;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
`endif
    end
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width (legal: 8, 16, 32, 64).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have ports A, B  input  WIDTH  operands.
REQ-007 SHALL have port functn  input  6  operation code.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports out, hi  output  WIDTH  result low word; high word (MULTU only, else 0).
REQ-011 SHALL have ports negativeFlag, zeroFlag, carryFlag, overflowFlag, illegalFlag  output  1  registered status.

Function
REQ-012 SHALL accept a request on a cycle with in_valid && in_ready, capturing A, B, functn.
REQ-013 SHALL drive in_ready = (state == IDLE) && (!out_valid || out_ready), permitting back-to-back single-cycle ops.
REQ-014 SHALL use states IDLE, MUL; IDLE->MUL on accepted MULTU, MUL->IDLE when iteration count reaches WIDTH.
REQ-015 SHALL complete ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SRL 000010, SRA 000011 with out_valid high the cycle after acceptance.
REQ-016 SHALL compute SLT signed and SLTU unsigned, out = 1 or 0.
REQ-017 SHALL take shift amount from B[$clog2(WIDTH)-1:0]; SRA sign-extends, SRL zero-fills.
REQ-018 SHALL compute MULTU by shift-add, one bit per cycle, {hi,out} = full 2*WIDTH unsigned product, out_valid asserting exactly WIDTH+1 cycles after acceptance.
REQ-019 SHALL set carryFlag = carry-out for ADD/ADDU, borrow (A < B unsigned) for SUB/SUBU, else 0.
REQ-020 SHALL set overflowFlag = signed overflow for ADD/SUB only, else 0.
REQ-021 SHALL set negativeFlag = out[WIDTH-1] (hi[WIDTH-1] for MULTU); zeroFlag = result (full 2*WIDTH for MULTU) equals 0.
REQ-022 SHALL, for any unlisted functn, complete in one cycle with out = hi = 0, illegalFlag = 1, zeroFlag = 1, other flags 0.
REQ-023 SHALL hold out, hi and all flags stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid on out_valid && out_ready unless a new request is accepted that same cycle.
REQ-025 SHALL ignore in_valid while in MUL or while holding an unaccepted result.

Reset
REQ-026 SHALL, on reset, force state IDLE, iteration counter 0, out_valid 0, out = hi = 0, all flags 0; in_ready 1 the cycle after reset deasserts.
REQ-027 SHALL abort an in-progress MULTU on reset with no result produced.

Configuration
REQ-028 SHALL, with macro ALU_MULTICYCLE_MULT_EN defined, implement MULTU (functn 011001) per REQ-018.
REQ-029 SHALL, without ALU_MULTICYCLE_MULT_EN, omit the MUL state and multiplier datapath and treat 011001 as illegal per REQ-022.

Verification
REQ-030 SHALL check ADD, A=32'h7FFFFFFF, B=1 -> next cycle out=32'h80000000, overflowFlag=1, negativeFlag=1, carryFlag=0.
REQ-031 SHALL check SUBU, A=3, B=4 -> out=32'hFFFFFFFF, carryFlag=1, overflowFlag=0.
REQ-032 SHALL check MULTU (macro on), A=B=32'hFFFFFFFF -> out_valid at cycle 33, hi=32'hFFFFFFFE, out=1, in_ready low cycles 1-32.
REQ-033 SHALL check SRA, A=32'h80000000, B=4 then SLT A=-1, B=1 back-to-back with out_ready=1 -> out=32'hF8000000 then 1, consecutive cycles.
REQ-034 SHALL check backpressure: AND result with out_ready=0 for 5 cycles -> out/flags stable, in_ready=0, new in_valid ignored.
REQ-035 SHALL check reset at cycle 10 of MULTU -> out_valid never asserts for it, all outputs 0, next ADD 2+2=4 correct.
